// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO between the UART receiver and the register read path.
// Optional idle-timeout flag is built only when UART_RXF_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter  int DEPTH   = 16,
  parameter  int WIDTH   = 8,
  parameter  int TIMEOUT = 1024,
  localparam int PW      = $clog2(DEPTH),
  localparam int LW      = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic             clr_i,
  input  logic [LW-1:0]    thresh_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [LW-1:0]    level_o,
  output logic             overflow_o,
  output logic             intr_rx_o,
  output logic             timeout_o
);

  // Handshake: wr_valid_i and rd_en_i are single-cycle strobes with no back-pressure.
  // A push is taken when not full or when a pop happens in the same cycle; a pop is
  // taken only when not empty. clr_i overrides both and drops any same-cycle push.

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;

  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;
  logic drop;

  always_comb begin
    full    = (level_q == LVL_MAX);
    empty   = (level_q == '0);
    push_ok = wr_valid_i & (~full | rd_en_i) & ~clr_i;
    pop_ok  = rd_en_i & ~empty & ~clr_i;
    drop    = wr_valid_i & full & ~rd_en_i & ~clr_i;
  end

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (clr_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = wr_data_i;
        wptr_d        = wptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      overflow_d = overflow_q | drop;
    end
  end

  // Array contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    rd_data_o  = empty ? '0 : mem_q[rptr_q];
    empty_o    = empty;
    full_o     = full;
    level_o    = level_q;
    overflow_o = overflow_q;
    // A threshold above DEPTH can never be reached, so it silently never fires.
    intr_rx_o  = (thresh_i != '0) & (level_q >= thresh_i);
  end

`ifdef UART_RXF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] IDLE_ONE = TW'(1);

  logic [TW-1:0] idle_q, idle_d;

  // Counts quiet cycles with data pending; saturates so the flag holds until activity.
  always_comb begin
    idle_d = idle_q;
    if (clr_i | push_ok | pop_ok | empty) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign timeout_o = (idle_q == IDLE_MAX) & ~empty;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver and upstream of the UART register interface. It captures each byte the receiver strobes out, holds up to DEPTH bytes in arrival order, and presents the oldest byte to the register read path first-word-fall-through. It reports level, full/empty, sticky overflow and a threshold interrupt, so software can drain bursts without losing bytes between register reads.

## Interface
- DEPTH, 16: number of byte entries; power of two, ≥ 2.
- WIDTH, 8: data width in bits.
- TIMEOUT, 1024: idle cycles before `timeout_o` asserts; used only with `UART_RXF_TIMEOUT_EN`.

Ports (LW = $clog2(DEPTH)+1):
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wr_valid_i  in  1  one-cycle strobe from the receiver: byte done.
- wr_data_i  in  WIDTH  received byte; sampled when `wr_valid_i` = 1.
- rd_en_i  in  1  pop strobe from the register read of the RX data address.
- clr_i  in  1  synchronous flush; also clears overflow.
- thresh_i  in  LW  interrupt threshold in bytes; 0 disables.
- rd_data_o  out  WIDTH  oldest byte (FWFT); 0 when empty.
- empty_o  out  1  level_o == 0.
- full_o  out  1  level_o == DEPTH.
- level_o  out  LW  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a byte was dropped.
- intr_rx_o  out  1  threshold interrupt.
- timeout_o  out  1  idle timeout with data pending.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer, read pointer (LW-1 bits each, wrapping modulo DEPTH), registered `level_o`.
- Push accepted = `wr_valid_i` & (~full | `rd_en_i`): byte written at wptr, wptr+1.
- Pop accepted = `rd_en_i` & ~empty: rptr+1.
- Level update: +1 on push only, −1 on pop only, unchanged on both.
- Full with push and pop together: both accepted, level stays DEPTH, no overflow.
- Full with push only: byte dropped, `overflow_o` set and held until `clr_i` or reset.
- Empty with push and pop together: push accepted, pop ignored, level becomes 1.
- Pop while empty: ignored. No underflow flag. Pointers are unchanged.
- `clr_i`: next edge sets pointers, level, overflow and timeout counter to 0. It takes priority over any simultaneous push or pop. A push in that same cycle is discarded and does not set overflow.
- `rd_data_o` = mem[rptr] when level ≠ 0, else 0.
- `intr_rx_o` = (thresh_i ≠ 0) & (level_o ≥ thresh_i), combinational from registered level. If thresh_i > DEPTH, it never asserts.

## Timing
- Reset: `level_o` = 0, `empty_o` = 1, `full_o` = 0, `overflow_o` = 0, `intr_rx_o` = 0, `timeout_o` = 0, `rd_data_o` = 0. Array contents are don't-care.
- Push latency: a push sampled at edge N makes the byte visible on `rd_data_o` and updates `level_o`/`empty_o` after edge N, in the same cycle.
- Pop latency: a pop at edge N presents the next entry (or 0 if now empty) after edge N.
- Back-to-back pushes on consecutive cycles are accepted at full rate. Pops are also accepted on every cycle.
- `overflow_o` rises after the edge that drops the byte.

## Configuration
- `UART_RXF_TIMEOUT_EN` defined:
  - An idle counter (width $clog2(TIMEOUT+1)) is cleared on reset, `clr_i`, any accepted push or pop, or while empty.
  - Otherwise it increments each cycle, saturating at TIMEOUT.
  - `timeout_o` = (count == TIMEOUT) & ~empty, so it asserts exactly TIMEOUT cycles after the last activity with data pending.
  - It falls after the edge of the next push, pop or clr.
- Not defined: no counter is built and `timeout_o` is tied to 0.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 on consecutive cycles -> level_o = 3, rd_data_o = 0x41. Three pops -> reads 0x41, 0x42, 0x43, then empty_o = 1, rd_data_o = 0.
- DEPTH=16: push 17 bytes with no pops -> full_o = 1, level_o = 16, overflow_o = 1. Draining returns the first 16 bytes in order; the 17th is absent.
- Full, then push 0x55 and pop in the same cycle -> level_o stays 16, no overflow. The last drained byte is 0x55. Pointers wrap correctly over 40 push/pop cycles.
- Empty, then push 0x7E and pop in the same cycle -> level_o = 1, rd_data_o = 0x7E.
- thresh_i = 4: push 3 -> intr_rx_o = 0; 4th push -> intr_rx_o = 1; one pop -> 0. thresh_i = 0 with 16 entries -> intr_rx_o = 0.
- With overflow set and level 5, assert clr_i together with a push -> level_o = 0, overflow_o = 0, empty_o = 1. With `UART_RXF_TIMEOUT_EN` and TIMEOUT = 8: one push then idle -> timeout_o = 1 exactly 8 cycles later, and clears after the next pop.
